// File: rtl/ppu_sched.sv
// PPU scheduler: round-robin grant of the post-processing unit to two requesters,
// sequencing tiles and accumulator rows per vector. Optional watchdog: PPU_SCHED_TIMEOUT_EN.
module ppu_sched #(
   parameter int TILES_PER_VEC = 4,
   parameter int ROWS_PER_TILE = 16,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_tile_rdy,
   input  logic       i_quant_done,
   input  logic       i_softmax_done,
   output logic       o_ppu_start,
   output logic [1:0] o_gnt,
   output logic [1:0] o_tile_idx,
   output logic [3:0] o_acc_row,
   output logic       o_busy,
   output logic       o_vec_done,
   output logic       o_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_NEXT,
      S_DRAIN
   } state_t;

   localparam logic [1:0] LAST_TILE = 2'(TILES_PER_VEC - 1);
   localparam logic [3:0] LAST_ROW  = 4'(ROWS_PER_TILE - 1);

   state_t     state;
   logic       rr_ptr;
   logic [1:0] gnt_next;
   logic       owner_done;

`ifdef PPU_SCHED_TIMEOUT_EN
   localparam logic [7:0] WDOG_LAST = 8'(DRAIN_TIMEOUT - 1);
   logic [7:0] wdog;
   logic       timeout_q;
   assign o_timeout = timeout_q;
`else
   wire unused_timeout_cfg = (DRAIN_TIMEOUT == 0);
   assign o_timeout = 1'b0;
`endif

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      gnt_next = i_req;
      if (i_req == 2'b11) gnt_next = rr_ptr ? 2'b10 : 2'b01;
   end

   // Only the owner's completion pulse counts; the other requester's is ignored.
   assign owner_done = (o_gnt[0] & i_quant_done) | (o_gnt[1] & i_softmax_done);

   // NOTE: sequential state uses non-blocking assignments only; all outputs are registered here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         rr_ptr      <= 1'b0;
         o_ppu_start <= 1'b0;
         o_gnt       <= 2'b00;
         o_tile_idx  <= 2'd0;
         o_acc_row   <= 4'd0;
         o_busy      <= 1'b0;
         o_vec_done  <= 1'b0;
`ifdef PPU_SCHED_TIMEOUT_EN
         wdog        <= 8'd0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         o_ppu_start <= 1'b0;
         o_vec_done  <= 1'b0;
`ifdef PPU_SCHED_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (|i_req) begin
                  o_gnt       <= gnt_next;
                  o_ppu_start <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= S_START;
               end
            end
            S_START: begin
               o_acc_row <= 4'd0;
               state     <= S_RUN;
            end
            S_RUN: begin
               if (o_acc_row == LAST_ROW) begin
                  if (o_tile_idx != LAST_TILE) begin
                     o_tile_idx <= o_tile_idx + 2'd1;
                     o_acc_row  <= 4'd0;
                     state      <= S_NEXT;
                  end else begin
`ifdef PPU_SCHED_TIMEOUT_EN
                     wdog <= 8'd0;
`endif
                     state <= S_DRAIN;
                  end
               end else begin
                  o_acc_row <= o_acc_row + 4'd1;
               end
            end
            S_NEXT: begin
               if (i_tile_rdy) begin
                  o_ppu_start <= 1'b1;
                  state       <= S_START;
               end
            end
            S_DRAIN: begin
               if (owner_done) begin
                  o_vec_done <= 1'b1;
                  o_gnt      <= 2'b00;
                  o_tile_idx <= 2'd0;
                  o_acc_row  <= 4'd0;
                  o_busy     <= 1'b0;
                  rr_ptr     <= ~rr_ptr;
                  state      <= S_IDLE;
`ifdef PPU_SCHED_TIMEOUT_EN
               end else if (wdog == WDOG_LAST) begin
                  timeout_q  <= 1'b1;
                  o_gnt      <= 2'b00;
                  o_tile_idx <= 2'd0;
                  o_acc_row  <= 4'd0;
                  o_busy     <= 1'b0;
                  rr_ptr     <= ~rr_ptr;
                  state      <= S_IDLE;
               end else begin
                  wdog <= wdog + 8'd1;
`endif
               end
            end
            default: begin
               o_gnt  <= 2'b00;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
